// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

    // Controller states: wait for start, one restoring step per clock, sign fix-up.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // Default operand/result width.
    localparam int DIV_W = 32;

    // Widest operand the magnitude helper supports; callers cast down to N.
    localparam int MAX_W = 64;

    // Two's-complement magnitude. -2^(N-1) sign-extended to MAX_W bits becomes
    // +2^(N-1), whose low N bits read correctly as an unsigned magnitude.
    function automatic logic [MAX_W-1:0] abs_n(input logic signed [MAX_W-1:0] v);
        return v[MAX_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/signed_divider_seq_div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the
// divisor magnitude, keep the difference if it did not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int N = DIV_W
) (
    input  logic [N:0]   rem_in,
    input  logic         bit_in,
    input  logic [N-1:0] dvs_mag,
    output logic [N:0]   rem_out,
    output logic         q_bit
);

    // One guard bit above the partial remainder carries the trial sign.
    logic [N+1:0] shifted;
    logic [N+1:0] trial;

    // Trial subtract and restore-or-keep selection.
    always_comb begin
        shifted = {rem_in, bit_in};
        trial   = shifted - {2'b00, dvs_mag};
        q_bit   = ~trial[N+1];
        rem_out = q_bit ? trial[N:0] : shifted[N:0];
    end

endmodule

// File: rtl/signed_divider_seq.sv
// Sequential signed divider: quotient truncated toward zero, remainder takes
// the dividend's sign. One restoring step per clock, start/done handshake.
// Optional feature macro: DIV_BY_ZERO_EN (zero divisor detected at accept,
// result all-ones quotient / unmodified dividend, dz flag raised).
module signed_divider_seq
    import div_pkg::*;
#(
    parameter int N  = DIV_W,
    parameter int CW = $clog2(N) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         dz
);

    div_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [N:0]    rem;       // partial remainder
    logic [N-1:0]  dq;        // dividend magnitude shifts out, quotient shifts in
    logic [N-1:0]  dvs_mag;
    logic          sign_q;
    logic          sign_r;

    logic [N:0]    rem_step;
    logic          q_bit;
    logic [N-1:0]  dvd_abs;
    logic [N-1:0]  dvs_abs;
    logic          last_step;
    logic          dvs_zero;
    logic          fix_hold;  // zero-divisor op spends one extra cycle in FIX

    assign dvd_abs   = N'(abs_n(MAX_W'(signed'(dividend))));
    assign dvs_abs   = N'(abs_n(MAX_W'(signed'(divisor))));
    assign last_step = (cnt == CW'(N - 1));

    div_step #(.N(N)) u_step (
        .rem_in  (rem),
        .bit_in  (dq[N-1]),
        .dvs_mag (dvs_mag),
        .rem_out (rem_step),
        .q_bit   (q_bit)
    );

`ifdef DIV_BY_ZERO_EN
    logic dz_pend;

    assign dvs_zero = (divisor == '0);
    assign fix_hold = dz_pend && (cnt == '0);

    // Remember a zero divisor from accept and publish the flag with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            dz_pend <= 1'b0;
            dz      <= 1'b0;
        end else begin
            if (state == IDLE && start)
                dz_pend <= dvs_zero;
            if (state == FIX && !fix_hold)
                dz <= dz_pend;
        end
    end
`else
    assign dvs_zero = 1'b0;
    assign fix_hold = 1'b0;
    assign dz       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state and busy decode.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        state_nxt = state;
        busy      = (state != IDLE);
        case (state)
            IDLE: if (start) state_nxt = dvs_zero ? FIX : CALC;
            CALC: if (last_step) state_nxt = FIX;
            FIX:  if (!fix_hold) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rem       <= '0;
            dq        <= '0;
            dvs_mag   <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        dvs_mag <= dvs_abs;
                        sign_r  <= dividend[N-1];
                        if (dvs_zero) begin
                            // Preload the final magnitudes so FIX reproduces the
                            // dividend and leaves the all-ones quotient unsigned.
                            rem    <= {1'b0, dvd_abs};
                            dq     <= '1;
                            sign_q <= 1'b0;
                        end else begin
                            rem    <= '0;
                            dq     <= dvd_abs;
                            sign_q <= dividend[N-1] ^ divisor[N-1];
                        end
                    end
                end
                CALC: begin
                    rem <= rem_step;
                    dq  <= {dq[N-2:0], q_bit};
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (fix_hold) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        quotient  <= sign_q ? -dq : dq;
                        remainder <= sign_r ? -rem[N-1:0] : rem[N-1:0];
                        done      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider_seq.sv
// Self-checking bench for signed_divider_seq (N=32). Expected results come from
// a magnitude-based arithmetic model; honours DIV_BY_ZERO_EN when defined.
module tb_signed_divider_seq;

    localparam int N   = 32;
    localparam int LAT = N + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  dividend = '0;
    logic [N-1:0]  divisor = '0;
    logic          busy;
    logic          done;
    logic [N-1:0]  quotient;
    logic [N-1:0]  remainder;
    logic          dz;

    int tests_run = 0;
    int tests_failed = 0;

    signed_divider_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    // Reference: divide magnitudes with plain integer arithmetic, then apply signs.
    // Returned vector layout: {busy after accept, latency[7:0], quotient, remainder, dz}.
    function automatic logic [73:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        longint sa, sb, ma, mb, qm, rm;
        logic [N-1:0] q, r;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
`ifdef DIV_BY_ZERO_EN
        // Zero divisor: done lands on the second edge after the accept edge.
        if (mb == 0) return {1'b1, 8'd2, {N{1'b1}}, a, 1'b1};
`endif
        if (mb == 0) begin
            qm = 64'h0000_0000_FFFF_FFFF;
            rm = ma;
        end else begin
            qm = ma / mb;
            rm = ma % mb;
        end
        q = ((sa < 0) != (sb < 0)) ? 32'(-qm) : 32'(qm);
        r = (sa < 0) ? 32'(-rm) : 32'(rm);
        return {1'b1, 8'(LAT), q, r, 1'b0};
    endfunction

    // Wait for done after an accept edge (called #1 after that edge); bounded.
    task automatic wait_done(inout int lat);
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Issue one operation and collect the observed result vector.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, output logic [73:0] got);
        int   lat;
        logic busy_seen;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        busy_seen = busy;
        lat       = 0;
        wait_done(lat);
        got = {busy_seen, 8'(lat), quotient, remainder, dz};
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, dz} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: busy/done/dz got %b expected 000", {busy, done, dz});
        end
        tests_run++;
        if (quotient !== '0) begin
            tests_failed++;
            $display("FAIL reset_quotient: got %h expected 0", quotient);
        end
        tests_run++;
        if (remainder !== '0) begin
            tests_failed++;
            $display("FAIL reset_remainder: got %h expected 0", remainder);
        end
        rst = 1'b0;
    endtask

    task automatic test_signs;
        logic [N-1:0] as [8] = '{32'd100, -32'sd100, 32'd100, -32'sd100,
                                 32'h8000_0000, 32'd7, 32'h8000_0000, 32'h7FFF_FFFF};
        logic [N-1:0] bs [8] = '{32'd7, 32'd7, -32'sd7, -32'sd7,
                                 32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'd1};
        logic [73:0] got, exp;
        for (int i = 0; i < 8; i++) begin
            do_op(as[i], bs[i], got);
            exp = model(as[i], bs[i]);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL signs[%0d] %h/%h: got %h expected %h", i, as[i], bs[i], got, exp);
            end
        end
    endtask

    task automatic test_ignore_start;
        logic [73:0] exp;
        int lat;
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            lat++;
        end
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        wait_done(lat);
        exp = model(32'd50, 32'd5);
        tests_run++;
        if ({8'(lat), quotient, remainder} !== exp[72:1]) begin
            tests_failed++;
            $display("FAIL ignore_start: lat/q/r got %h expected %h",
                     {8'(lat), quotient, remainder}, exp[72:1]);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if ({done, busy, quotient} !== {2'b00, exp[64:33]}) begin
            tests_failed++;
            $display("FAIL done_pulse_hold: done/busy/q got %h expected %h",
                     {done, busy, quotient}, {2'b00, exp[64:33]});
        end
    endtask

    task automatic test_back_to_back;
        logic [73:0] got, exp;
        do_op(32'd1000, -32'sd9, got);
        exp = model(32'd1000, -32'sd9);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h expected %h", got, exp);
        end
        // Still inside the done cycle: start is accepted on the very next edge.
        do_op(32'd9, 32'd3, got);
        exp = model(32'd9, 32'd3);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_reset_mid;
        logic [73:0] got, exp;
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tests_run++;
        if ({busy, done, dz, quotient, remainder} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy/done/dz/q/r got %h expected 0",
                     {busy, done, dz, quotient, remainder});
        end
        do_op(32'd1000, 32'd3, got);
        exp = model(32'd1000, 32'd3);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL after_reset_op: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_div_zero;
        logic [73:0] got, exp;
        logic [N-1:0] as [3] = '{-32'sd25, 32'd77, 32'h8000_0000};
        for (int i = 0; i < 3; i++) begin
            do_op(as[i], 32'd0, got);
            exp = model(as[i], 32'd0);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL div_zero[%0d] %h/0: got %h expected %h", i, as[i], got, exp);
            end
        end
    endtask

    task automatic test_random;
        logic [73:0] got, exp;
        logic [N-1:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3, 4: b = 32'($urandom_range(0, 30)) - 32'd15;
                5:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            do_op(a, b, got);
            exp = model(a, b);
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL random[%0d] %h/%h: got %h expected %h", i, a, b, got, exp);
            end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_signs();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_div_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/signed_divider_seq.md
Name: signed_divider_seq

Overview:
Sequential signed integer divider: the inverse companion of the team's right-shift sequential signed multiplier.
- Computes quotient and remainder of two's-complement operands, one restoring subtract-shift step per clock.
- Sits in the same arithmetic datapath. Uses a start/done handshake so a controller can chain it with the multiplier.

Parameters:
- N, 32, operand/result width in bits (N >= 4).
- CW, $clog2(N)+1, iteration counter width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- dividend  in  N  signed dividend; captured on accepted start.
- divisor  in  N  signed divisor; captured on accepted start.
- busy  out  1  high from the accept edge until the result is written.
- done  out  1  one-cycle pulse; results valid while done=1 and held until the next accept.
- quotient  out  N  signed quotient, truncated toward zero.
- remainder  out  N  signed remainder; sign equals dividend sign (or zero).
- dz  out  1  divide-by-zero flag, valid with done (feature-dependent).

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; busy=0, done=0, quotient=0, remainder=0, dz=0, counter=0. Reset mid-operation aborts at once; the partial result is discarded.
- States: IDLE, CALC, FIX.
- IDLE, start=1 at edge k (accept):
  - Latch |dividend|, |divisor|, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
  - Clear the partial remainder (N+1 bits). Set counter=0, busy=1, done=0. Go to CALC.
- CALC, each edge:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude from the upper N+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Increment counter. On the edge where counter reaches N-1 (the Nth step), go to FIX.
- FIX, one edge:
  - quotient = sign_q ? -q_mag : q_mag; remainder = sign_r ? -r_mag : r_mag, both mod 2^N.
  - done=1, busy=0. Go to IDLE.
- Latency: accept at edge k gives done=1 during the cycle after edge k+N+1, i.e. N+1 clocks. done clears at the next edge.
- start while busy is ignored, with no queuing. start held high in IDLE on the cycle done=1 is accepted, giving back-to-back operation.
- Operand changes after accept have no effect.
- Overflow: -2^(N-1) / -1 gives quotient = -2^(N-1) (wraps), remainder=0. No flag.
- Magnitude of -2^(N-1) is handled as unsigned 2^(N-1); the N-bit magnitude path is unsigned.

Optional Feature:
- Macro DIV_BY_ZERO_EN.
- Defined:
  - divisor==0 is detected at accept; CALC is skipped (IDLE->FIX).
  - done asserts 2 clocks after accept with quotient = all ones, remainder = dividend (unmodified), dz=1.
  - dz=0 for all other operations.
- Undefined:
  - No detection; dz is tied to 0 and latency is always N+1.
  - Divisor 0 runs the normal algorithm: q_mag = all ones, r_mag = |dividend|, then the normal sign fix.

Decomposition:
- Package div_pkg:
  - State enum div_state_t {IDLE, CALC, FIX}.
  - Default width constant DIV_W=32.
  - Helper function abs_n for the magnitude conversion.
- One natural sub-module, div_step: combinational restoring step taking partial remainder, dividend bit, and divisor magnitude, returning next remainder and quotient bit. Instantiated once inside signed_divider_seq.

Test Plan:
1. 100 / 7 -> done after 33 clocks, quotient=14, remainder=2, dz=0. -100 / 7 -> quotient=-14, remainder=-2.
2. 100 / -7 -> quotient=-14, remainder=2. -100 / -7 -> quotient=14, remainder=-2.
3. -2147483648 / -1 -> quotient=32'h8000_0000, remainder=0. 7 / 100 -> quotient=0, remainder=7.
4. Accept 50/5, pulse start with 9/3 at clock 10 -> ignored; result quotient=10, remainder=0. Then start held high at done -> 9/3 accepted same cycle, quotient=3.
5. Assert rst at clock 15 of 1000/3 -> next cycle busy=0, done=0, quotient=0, remainder=0. A new 1000/3 then gives quotient=333, remainder=1.
6. DIV_BY_ZERO_EN defined: -25 / 0 -> done 2 clocks after accept, quotient=32'hFFFF_FFFF, remainder=-25, dz=1. Undefined: dz stays 0 and done after 33 clocks.
